// File: rtl/x_ramb_sp_gen.sv
// Single-port synchronous block RAM: byte-lane write enables, selectable write mode, output SSR.
// Define X_RAMB_SP_OREG_EN to add a REGCE-gated second output register (read latency 2).
module x_ramb_sp_gen #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PAR_W  = DATA_W / 8,
  parameter int unsigned NB     = DATA_W / 8,
  parameter string       WRITE_MODE = "WRITE_FIRST",
  parameter logic [DATA_W+PAR_W-1:0] INIT_WORD = '0,
  parameter logic [DATA_W+PAR_W-1:0] SRVAL     = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              SSR,
  input  logic [NB-1:0]     WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DI,
  input  logic [PAR_W-1:0]  DIP,
  input  logic              REGCE,
  output logic [DATA_W-1:0] DO,
  output logic [PAR_W-1:0]  DOP,
  output logic              DOV
);

  localparam int unsigned WORD_W = DATA_W + PAR_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam bit MODE_WF = (WRITE_MODE == "WRITE_FIRST");
  localparam bit MODE_RF = (WRITE_MODE == "READ_FIRST");
  localparam bit MODE_NC = (WRITE_MODE == "NO_CHANGE");

  // Elaboration-time parameter sanity checks
  if ((DATA_W % 8) != 0 || DATA_W == 0 || PAR_W != DATA_W / 8 || NB != DATA_W / 8) begin : g_bad_width
    $error("x_ramb_sp_gen: DATA_W must be a nonzero multiple of 8 with PAR_W = NB = DATA_W/8");
  end
  if (!(MODE_WF || MODE_RF || MODE_NC)) begin : g_bad_mode
    $error("x_ramb_sp_gen: WRITE_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
  end

  // Word layout is {parity, data}; parity bit i belongs to data lane i
  logic [WORD_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] lat_word;
  logic              lat_v;

  assign rd_word = mem[ADDR];

  // Merge new lanes over the stored word
  always_comb begin
    wr_word = rd_word;
    for (int i = 0; i < int'(NB); i++) begin
      if (WE[i]) begin
        wr_word[8*i +: 8]  = DI[8*i +: 8];
        wr_word[DATA_W+i]  = DIP[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (EN && RST_N && (WE != '0)) begin
      mem[ADDR] <= wr_word;
    end
  end

  // Output latch; DOV marks a cycle in which a memory word was loaded
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_word <= SRVAL;
      lat_v    <= 1'b0;
    end else if (EN) begin
      if (SSR) begin
        lat_word <= SRVAL;
        lat_v    <= 1'b0;
      end else if (WE == '0) begin
        lat_word <= rd_word;
        lat_v    <= 1'b1;
      end else if (MODE_WF) begin
        lat_word <= wr_word;
        lat_v    <= 1'b1;
      end else if (MODE_RF) begin
        lat_word <= rd_word;
        lat_v    <= 1'b1;
      end else begin
        lat_v    <= 1'b0;
      end
    end else begin
      lat_v <= 1'b0;
    end
  end

`ifdef X_RAMB_SP_OREG_EN
  logic [WORD_W-1:0] oreg_word;
  logic              oreg_v;

  // Second stage advances on REGCE and honours SSR on its own
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      oreg_word <= SRVAL;
      oreg_v    <= 1'b0;
    end else if (REGCE) begin
      if (SSR) begin
        oreg_word <= SRVAL;
        oreg_v    <= 1'b0;
      end else begin
        oreg_word <= lat_word;
        oreg_v    <= lat_v;
      end
    end
  end

  assign DO  = oreg_word[DATA_W-1:0];
  assign DOP = oreg_word[WORD_W-1:DATA_W];
  assign DOV = oreg_v;
`else
  logic unused_regce;
  assign unused_regce = REGCE;

  assign DO  = lat_word[DATA_W-1:0];
  assign DOP = lat_word[WORD_W-1:DATA_W];
  assign DOV = lat_v;
`endif

endmodule
